// File: rtl/cpu_pkg.sv
// Shared widths and types for the ARM pipeline datapath.
// Flag and memory-control structs are packed so they drop straight into registers.
package cpu_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
  } mem_ctrl_t;

  function automatic flags_t calc_flags(input logic [DATA_W-1:0] result,
                                        input logic overflow,
                                        input logic carry);
    flags_t f;
    f.n = result[DATA_W-1];
    f.z = ~|result;
    f.v = overflow;
    f.c = carry;
    return f;
  endfunction

endpackage

// File: rtl/ex_mem_stage_reg_if.sv
// EX -> MEM boundary bundle: EX-side inputs, MEM-side registered outputs, flag bypass.
// master = the EX stage / surrounding pipeline, slave = the stage register itself.
interface ex_mem_stage_reg_if #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
);
  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic [DATA_W-1:0]     alu_result;
  logic                  alu_carry;
  logic                  alu_overflow;
  logic                  set_flags;
  logic [DATA_W-1:0]     store_data;
  logic [REG_ADDR_W-1:0] rd;
  logic                  reg_write;
  logic                  mem_write;
  logic                  mem_read;
  logic                  mem_to_reg;

  logic                  out_valid;
  logic [DATA_W-1:0]     result_q;
  logic [DATA_W-1:0]     store_data_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q;
  logic                  mem_write_q;
  logic                  mem_read_q;
  logic                  mem_to_reg_q;
  logic [3:0]            flags_q;
  logic [3:0]            flags_fwd;

  modport master (
    output stall, flush, in_valid, alu_result, alu_carry, alu_overflow, set_flags,
           store_data, rd, reg_write, mem_write, mem_read, mem_to_reg,
    input  out_valid, result_q, store_data_q, rd_q, reg_write_q, mem_write_q,
           mem_read_q, mem_to_reg_q, flags_q, flags_fwd
  );

  modport slave (
    input  stall, flush, in_valid, alu_result, alu_carry, alu_overflow, set_flags,
           store_data, rd, reg_write, mem_write, mem_read, mem_to_reg,
    output out_valid, result_q, store_data_q, rd_q, reg_write_q, mem_write_q,
           mem_read_q, mem_to_reg_q, flags_q, flags_fwd
  );
endinterface

// File: rtl/ex_mem_stage_reg_flag_unit.sv
// NZVC formation from the ALU output, architectural flag register and B.cond bypass.
// The register only moves when a real flag-setting instruction is accepted.
module flag_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              carry,
  input  logic              overflow,
  input  logic              set_flags,
  input  logic              in_valid,
  output cpu_pkg::flags_t   flags_q,
  output cpu_pkg::flags_t   flags_fwd
);
  import cpu_pkg::*;

  flags_t flags_next;
  flags_t flags_reg;
  logic   flag_write;

  always_comb begin
    flags_next   = '0;
    flags_next.n = alu_result[DATA_W-1];
    flags_next.z = ~|alu_result;
    flags_next.v = overflow;
    flags_next.c = carry;
  end

  assign flag_write = in_valid & set_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= '0;
    end else if (enable && flag_write) begin
      flags_reg <= flags_next;
    end
  end

  // A B.cond right behind a SUBS sees the new flags before they are registered.
  assign flags_fwd = flag_write ? flags_next : flags_reg;
  assign flags_q   = flags_reg;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with stall/flush and architectural flag handling.
// Define EXMEM_PERF_CNT_EN to add saturating stall_cnt / bubble_cnt outputs.
module ex_mem_stage_reg #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  ex_mem_stage_reg_if.slave  bus
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
`endif
);
  import cpu_pkg::*;

  logic                  valid_reg;
  logic [DATA_W-1:0]     result_reg;
  logic [DATA_W-1:0]     store_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  mem_ctrl_t             ctrl_reg;
  mem_ctrl_t             ctrl_next;
  flags_t                flags_q_w;
  flags_t                flags_fwd_w;

  always_comb begin
    ctrl_next            = '0;
    ctrl_next.reg_write  = bus.reg_write;
    ctrl_next.mem_write  = bus.mem_write;
    ctrl_next.mem_read   = bus.mem_read;
    ctrl_next.mem_to_reg = bus.mem_to_reg;
  end

  // Data fields are left untouched on flush; only valid and control are cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      result_reg <= '0;
      store_reg  <= '0;
      rd_reg     <= '0;
      ctrl_reg   <= '0;
    end else if (bus.flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (!bus.stall) begin
      valid_reg  <= bus.in_valid;
      result_reg <= bus.alu_result;
      store_reg  <= bus.store_data;
      rd_reg     <= bus.rd;
      ctrl_reg   <= bus.in_valid ? ctrl_next : '0;
    end
  end

  flag_unit #(.DATA_W(DATA_W)) u_flag_unit (
    .clk        (clk),
    .reset      (reset),
    .enable     (~bus.stall & ~bus.flush),
    .alu_result (bus.alu_result),
    .carry      (bus.alu_carry),
    .overflow   (bus.alu_overflow),
    .set_flags  (bus.set_flags),
    .in_valid   (bus.in_valid),
    .flags_q    (flags_q_w),
    .flags_fwd  (flags_fwd_w)
  );

  assign bus.out_valid    = valid_reg;
  assign bus.result_q     = result_reg;
  assign bus.store_data_q = store_reg;
  assign bus.rd_q         = rd_reg;
  assign bus.reg_write_q  = ctrl_reg.reg_write;
  assign bus.mem_write_q  = ctrl_reg.mem_write;
  assign bus.mem_read_q   = ctrl_reg.mem_read;
  assign bus.mem_to_reg_q = ctrl_reg.mem_to_reg;
  assign bus.flags_q      = flags_q_w;
  assign bus.flags_fwd    = flags_fwd_w;

`ifdef EXMEM_PERF_CNT_EN
  logic [1:0]  cnt_inc;
  logic [31:0] cnt_out [2];

  // [0] stall cycles, [1] edges that load a bubble (flush or invalid without stall).
  assign cnt_inc[0] = bus.stall;
  assign cnt_inc[1] = bus.flush | (~bus.stall & ~bus.in_valid);

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
    assign cnt_out[gi] = cnt_reg;
  end

  assign stall_cnt  = cnt_out[0];
  assign bubble_cnt = cnt_out[1];
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed self-checking bench for ex_mem_stage_reg (optionally with EXMEM_PERF_CNT_EN).
// One info line per step; expected values are hand-computed constants.
module tb_ex_mem_stage_reg;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  ex_mem_stage_reg_if #(.DATA_W(64), .REG_ADDR_W(5)) bus ();

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  ex_mem_stage_reg #(.DATA_W(64), .REG_ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef EXMEM_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic c, input logic ov,
                       input logic sf, input logic [63:0] sd, input logic [4:0] r,
                       input logic rw, input logic mw, input logic mr, input logic m2r);
    bus.in_valid     = v;
    bus.alu_result   = res;
    bus.alu_carry    = c;
    bus.alu_overflow = ov;
    bus.set_flags    = sf;
    bus.store_data   = sd;
    bus.rd           = r;
    bus.reg_write    = rw;
    bus.mem_write    = mw;
    bus.mem_read     = mr;
    bus.mem_to_reg   = m2r;
  endtask

  initial begin
    // Reset with busy inputs held for two edges
    $display("step reset");
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1'b0, 64'hFFFF, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result_q", bus.result_q, 0);
    chk("rst_store_q", bus.store_data_q, 0);
    chk("rst_rd_q", bus.rd_q, 0);
    chk("rst_ctrl_q", {bus.reg_write_q, bus.mem_write_q, bus.mem_read_q, bus.mem_to_reg_q}, 0);
    chk("rst_flags_q", bus.flags_q, 0);
    chk("rst_flags_fwd", bus.flags_fwd, 0);
`ifdef EXMEM_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
`endif

    // Load a negative result with flag setting
    $display("step load_negative");
    reset = 1'b0;
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("load_fwd_bypass", bus.flags_fwd, 4'b1000);
    tick();
    chk("load_out_valid", bus.out_valid, 1);
    chk("load_result_q", bus.result_q, 64'h8000_0000_0000_0000);
    chk("load_store_q", bus.store_data_q, 64'h1234);
    chk("load_rd_q", bus.rd_q, 5);
    chk("load_reg_write_q", bus.reg_write_q, 1);
    chk("load_mem_write_q", bus.mem_write_q, 0);
    chk("load_flags_q", bus.flags_q, 4'b1000);

    // Zero result with carry, destination X31
    $display("step zero_bypass");
    drive(1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 64'h0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    chk("zero_fwd_bypass", bus.flags_fwd, 4'b0101);
    chk("zero_flags_q_pre", bus.flags_q, 4'b1000);
    tick();
    chk("zero_flags_q", bus.flags_q, 4'b0101);
    chk("zero_rd_q_x31", bus.rd_q, 31);
    chk("zero_mem_read_q", bus.mem_read_q, 1);
    chk("zero_mem_to_reg_q", bus.mem_to_reg_q, 1);

    // Load DEAD without flag setting: flags hold, fwd shows the register
    $display("step load_dead");
    drive(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("dead_fwd_reg", bus.flags_fwd, 4'b0101);
    tick();
    chk("dead_result_q", bus.result_q, 64'hDEAD);
    chk("dead_flags_q", bus.flags_q, 4'b0101);

    // Stall three cycles with a flag-setting BEEF waiting
    $display("step stall");
    bus.stall = 1'b1;
    drive(1'b1, 64'hBEEF, 1'b0, 1'b1, 1'b1, 64'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall_fwd_bypass", bus.flags_fwd, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("step stall_cycle %0d", i);
      chk("stall_result_q", bus.result_q, 64'hDEAD);
      chk("stall_flags_q", bus.flags_q, 4'b0101);
      chk("stall_rd_q", bus.rd_q, 3);
      chk("stall_out_valid", bus.out_valid, 1);
    end

    // Flush together with stall
    $display("step flush_over_stall");
    bus.flush = 1'b1;
    drive(1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_mem_write_q", bus.mem_write_q, 0);
    chk("flush_reg_write_q", bus.reg_write_q, 0);
    chk("flush_flags_q", bus.flags_q, 4'b0101);

    // Plain store after the bubble
    $display("step store");
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(1'b1, 64'h100, 1'b0, 1'b0, 1'b0, 64'hCAFE, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("store_out_valid", bus.out_valid, 1);
    chk("store_mem_write_q", bus.mem_write_q, 1);
    chk("store_store_q", bus.store_data_q, 64'hCAFE);

    // Invalid instruction with control asserted, two cycles
    $display("step invalid_gating");
    drive(1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("inv_fwd_reg", bus.flags_fwd, 4'b0101);
    tick();
    tick();
    chk("inv_out_valid", bus.out_valid, 0);
    chk("inv_ctrl_q", {bus.reg_write_q, bus.mem_write_q, bus.mem_read_q, bus.mem_to_reg_q}, 0);
    chk("inv_flags_q", bus.flags_q, 4'b0101);
`ifdef EXMEM_PERF_CNT_EN
    chk("cnt_bubble", bubble_cnt, 3);
    chk("cnt_stall", stall_cnt, 4);
`endif

    // Reset arriving during a stall
    $display("step reset_mid_stall");
    drive(1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 64'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bus.stall = 1'b1;
    tick();
    chk("pre_rst_result_q", bus.result_q, 64'h55);
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_result_q", bus.result_q, 0);
    chk("mid_rst_rd_q", bus.rd_q, 0);
    chk("mid_rst_flags_q", bus.flags_q, 0);
`ifdef EXMEM_PERF_CNT_EN
    chk("mid_rst_stall_cnt", stall_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
